rtc_bus_master: RTL and testbench
=================================

# rtc_bus_master

Parametrised master for a multiplexed address/data RTC bus with active-low CS/RD/WR strobes and an A/D select line. It supersedes the fixed-timing single-access control generator. It adds programmable setup, strobe and hold phase lengths, burst access over consecutive RTC registers with address auto-increment, and a byte-level data handshake toward the microcontroller port logic. It sits between the port-decode registers and the RTC chip pins, and it owns the tri-state data bus.

## Interface
- SU_CYC, 2, setup cycles per phase (≥1)
- PW_CYC, 4, strobe-low cycles per phase (≥1)
- H_CYC, 2, hold cycles per phase (≥1)
- BURST_W, 4, width of burst_len
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; accepted only when busy=0
- wr_nrd  in  1  1=write, 0=read; latched on start
- addr  in  8  first RTC register address; latched on start
- burst_len  in  BURST_W  transfer count minus one; latched on start
- wr_data  in  8  write byte; must be valid while wr_data_req=1
- wr_data_req  out  1  one-cycle request for the next write byte
- rd_data  out  8  last byte read
- rd_valid  out  1  one-cycle strobe qualifying rd_data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the transfer completes
- rtc_cs_n, rtc_rd_n, rtc_wr_n  out  1 each  RTC strobes, active low
- rtc_ad  out  1  0=address phase, 1=data phase
- rtc_bus  inout  8  multiplexed A/D bus

## Operation
- States: IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE. A down-counter times each state: SU_CYC, PW_CYC or H_CYC cycles.
- IDLE: on start, latch wr_nrd, addr, and cnt=burst_len, then go to A_SU. start while busy=1 is ignored.
- Address phase (A_*): rtc_ad=0 and rtc_bus drives the current address. rtc_wr_n=0 only in A_PW.
- On the last A_H cycle of a write, wr_data_req=1. wr_data is captured into the data register at the end of that cycle.
- Data phase (D_*): rtc_ad=1.
  - Write: rtc_bus drives the data register and rtc_wr_n=0 in D_PW.
  - Read: rtc_bus is hi-Z for all of D_*. rtc_rd_n=0 in D_PW.
- Read capture: rtc_bus is sampled at the clock edge ending the last D_PW cycle. rd_data is updated and rd_valid=1 during the first D_H cycle.
- End of D_H:
  - If cnt≠0: cnt−1, address+1 (8-bit wrap, 0xFF→0x00), go to A_SU.
  - Otherwise go to DONE.
- DONE: one cycle with done=1, then IDLE. busy is 0 in DONE.
- rtc_cs_n=0 in every A_*/D_* state, continuously across burst bytes. It is 1 in IDLE and DONE.
- rtc_bus is driven only in A_* states and in write-mode D_* states; hi-Z otherwise.
- Reset values: rtc_cs_n=rtc_rd_n=rtc_wr_n=1, rtc_ad=0, rtc_bus hi-Z, busy=done=rd_valid=wr_data_req=0, rd_data=0x00, state IDLE.

## Timing
- All outputs are registered and state-decoded. Strobes never glitch.
- Per byte: 2·(SU_CYC+PW_CYC+H_CYC) cycles; 16 with defaults.
- Transfer latency: start → done = 1 + (burst_len+1)·2·(SU+PW+H) cycles.
- start and reset in the same cycle: reset wins.
- Reset mid-transfer: at the next edge all strobes are deasserted and the bus is released. No done or rd_valid is produced.
- start asserted during DONE is ignored. A new start is accepted from the following IDLE cycle.
- In any one cycle, at most one of rtc_rd_n and rtc_wr_n is low.

## Configuration
- RTC_BURST_EN defined: burst behaviour as above.
- Undefined:
  - burst_len is ignored and treated as 0; every transfer is exactly one byte.
  - The cnt register and the address incrementer are removed.

## Test plan
- SU=1, PW=2, H=1; single write, addr=0x21, wr_data=0x59:
  - wr_data_req pulses once.
  - Bus shows 0x21 during A_*, then 0x59 during D_*.
  - One wr_n pulse of 2 cycles in each phase.
  - done at cycle 9 after start.
- Single read, addr=0x22, model drives 0x13 during D_PW:
  - rd_valid once with rd_data=0x13.
  - Bus hi-Z throughout D_*.
  - rd_n low exactly 2 cycles.
- Burst read, addr=0xFE, burst_len=2 (RTC_BURST_EN):
  - Addresses 0xFE, 0xFF, 0x00 are issued.
  - Three rd_valid pulses.
  - rtc_cs_n stays low for 24 cycles.
  - done once.
- Reset asserted during the D_PW of a write:
  - Next cycle: all strobes high, bus hi-Z, busy=0, no done.
  - A subsequent start works normally.
- start pulsed while busy=1:
  - Ignored; exactly one done.
  - Then a start issued in the cycle after DONE is accepted.
- Build without RTC_BURST_EN, burst_len=3: exactly one byte is transferred and done arrives after 9 cycles (SU=1, PW=2, H=1).

Source files
------------

// File: rtl/rtc_bus_master_if.sv
// Host-side handshake between the port-decode logic and rtc_bus_master.
// The host (master modport) issues transfer requests and supplies write bytes.
// The bus master (slave modport) answers with status, read bytes and data requests.
interface rtc_bus_master_if #(
  parameter int BURST_W = 4
);
  logic               start;
  logic               wr_nrd;
  logic [7:0]         addr;
  logic [BURST_W-1:0] burst_len;
  logic [7:0]         wr_data;
  logic               wr_data_req;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, wr_nrd, addr, burst_len, wr_data,
    input  wr_data_req, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  start, wr_nrd, addr, burst_len, wr_data,
    output wr_data_req, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/rtc_bus_master.sv
// Master for a multiplexed address/data RTC bus with programmable setup,
// strobe and hold lengths. Each byte is an address phase followed by a data
// phase; every pin output is registered from the next-state decode, so the
// strobes cannot glitch.
// Optional feature macro: RTC_BURST_EN -- when defined, burst_len+1 consecutive
// registers are accessed with address auto-increment; when undefined every
// transfer is a single byte and burst_len is ignored.
module rtc_bus_master #(
  parameter int SU_CYC  = 2,
  parameter int PW_CYC  = 4,
  parameter int H_CYC   = 2,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_master_if.slave    host,
  output logic               rtc_cs_n,
  output logic               rtc_rd_n,
  output logic               rtc_wr_n,
  output logic               rtc_ad,
  inout  wire  [7:0]         rtc_bus
);

  localparam int MAX_CYC = (SU_CYC > PW_CYC) ? ((SU_CYC > H_CYC) ? SU_CYC : H_CYC)
                                             : ((PW_CYC > H_CYC) ? PW_CYC : H_CYC);
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rd_cap;

  logic          cs_n_q, rd_n_q, wr_n_q, ad_q, oe_q;
  logic [7:0]    dout_q;
  logic          busy_q, done_q, req_q, rd_valid_q;
  logic [7:0]    rd_data_q;

`ifdef RTC_BURST_EN
  logic [BURST_W-1:0] cnt_q, cnt_d;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^host.burst_len;
`endif

  // Cycles spent in a timed state, minus one (the down-counter load value).
  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      A_SU, D_SU: return TW'(SU_CYC - 1);
      A_PW, D_PW: return TW'(PW_CYC - 1);
      A_H,  D_H:  return TW'(H_CYC - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic logic is_addr(input state_t s);
    return (s == A_SU) || (s == A_PW) || (s == A_H);
  endfunction

  function automatic logic is_data(input state_t s);
    return (s == D_SU) || (s == D_PW) || (s == D_H);
  endfunction

  // Next-state, phase timer and latched transfer context.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_cap  = 1'b0;
`ifdef RTC_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (host.start) begin
          state_d = A_SU;
          wr_d    = host.wr_nrd;
          addr_d  = host.addr;
`ifdef RTC_BURST_EN
          cnt_d   = host.burst_len;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (tcnt_q != '0) begin
          tcnt_d = tcnt_q - TW'(1);
        end else begin
          case (state_q)
            A_SU: state_d = A_PW;
            A_PW: state_d = A_H;
            A_H: begin
              state_d = D_SU;
              if (wr_q) data_d = host.wr_data;
            end
            D_SU: state_d = D_PW;
            D_PW: begin
              state_d = D_H;
              rd_cap  = !wr_q;
            end
            D_H: begin
`ifdef RTC_BURST_EN
              if (cnt_q != '0) begin
                cnt_d   = cnt_q - BURST_W'(1);
                addr_d  = addr_q + 8'd1;
                state_d = A_SU;
              end else begin
                state_d = DONE;
              end
`else
              state_d = DONE;
`endif
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
    // Every state change reloads the timer for the state being entered.
    if (state_d != state_q) tcnt_d = phase_len(state_d);
  end

  // Control state and registered pin/status decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      wr_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
`ifdef RTC_BURST_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      wr_q       <= wr_d;
      cs_n_q     <= !(is_addr(state_d) || is_data(state_d));
      rd_n_q     <= !((state_d == D_PW) && !wr_d);
      wr_n_q     <= !((state_d == A_PW) || ((state_d == D_PW) && wr_d));
      ad_q       <= is_data(state_d);
      oe_q       <= is_addr(state_d) || (is_data(state_d) && wr_d);
      busy_q     <= is_addr(state_d) || is_data(state_d);
      done_q     <= (state_d == DONE);
      req_q      <= (state_d == A_H) && (tcnt_d == '0) && wr_d;
      rd_valid_q <= rd_cap;
      if (rd_cap) rd_data_q <= rtc_bus;
`ifdef RTC_BURST_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Address/data holding registers and the bus output value; no reset needed.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    dout_q <= is_addr(state_d) ? addr_d : data_d;
  end

  assign rtc_bus          = oe_q ? dout_q : 8'hzz;
  assign rtc_cs_n         = cs_n_q;
  assign rtc_rd_n         = rd_n_q;
  assign rtc_wr_n         = wr_n_q;
  assign rtc_ad           = ad_q;
  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.wr_data_req = req_q;
  assign host.rd_valid    = rd_valid_q;
  assign host.rd_data     = rd_data_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Testbench for rtc_bus_master: directed scenarios plus randomized transfers,
// each cycle compared with a phase-position model of the bus protocol.
module tb_rtc_bus_master;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int H    = 1;
  localparam int BW   = 4;
  localparam int HALF = S + P + H;
  localparam int L    = 2 * HALF;
`ifdef RTC_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad;
  wire  [7:0] rtc_bus;
  logic       tb_oe;
  logic [7:0] tb_dout;

  int n_err;
  int n_chk;

  logic [7:0] mem  [256];
  logic [7:0] wdat [16];

  always #5 clk = ~clk;

  assign rtc_bus = tb_oe ? tb_dout : 8'hzz;

  rtc_bus_master_if #(.BURST_W(BW)) host ();

  rtc_bus_master #(
    .SU_CYC(S), .PW_CYC(P), .H_CYC(H), .BURST_W(BW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .host     (host),
    .rtc_cs_n (rtc_cs_n),
    .rtc_rd_n (rtc_rd_n),
    .rtc_wr_n (rtc_wr_n),
    .rtc_ad   (rtc_ad),
    .rtc_bus  (rtc_bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {cs_n, rd_n, wr_n, ad, busy, done, wr_data_req, rd_valid}
  function automatic logic [7:0] pins();
    return {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad,
            host.busy, host.done, host.wr_data_req, host.rd_valid};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      host.start = 1'b0;
      host.addr  = 8'($urandom);
      tb_oe      = 1'b1;
      tb_dout    = 8'($urandom);
      @(negedge clk);
      chk("idle_pins", pins(), 8'hE0);
      chk("idle_bus", rtc_bus, tb_dout);
    end
  endtask

  // One transfer from the start cycle through DONE. poke_busy / poke_done
  // pulse a stray start while busy / during DONE; rst_at>0 asserts reset in
  // that cycle and then checks the aborted state.
  task automatic run_xfer(input bit wr, input logic [7:0] a, input logic [BW-1:0] bl,
                          input bit poke_busy, input bit poke_done, input int rst_at,
                          input logic [7:0] d0);
    int n, total, b, o, p, seg;
    bit dph;
    logic [7:0] ab, exp_bus, ev;
    n = BURST ? int'(bl) + 1 : 1;
    total = 1 + n * L;
    for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
    wdat[0] = d0;
    ab = a;
    exp_bus = 8'h00;
    @(posedge clk); #1;
    host.start = 1'b1; host.wr_nrd = wr; host.addr = a; host.burst_len = bl;
    tb_oe = 1'b1; tb_dout = 8'($urandom);
    @(negedge clk);
    chk("start_pins", pins(), 8'hE0);
    for (int k = 1; k <= total; k++) begin
      @(posedge clk); #1;
      host.start     = (poke_busy && k == 3) || (poke_done && k == total);
      host.wr_nrd    = 1'($urandom);
      host.addr      = 8'($urandom);
      host.burst_len = BW'($urandom);
      host.wr_data   = 8'($urandom);
      if (k == total) begin
        tb_oe = 1'b1; tb_dout = 8'($urandom); ev = 8'hE4;
      end else begin
        b   = (k - 1) / L;
        o   = (k - 1) % L;
        dph = (o >= HALF);
        p   = o % HALF;
        seg = (p < S) ? 0 : ((p < S + P) ? 1 : 2);
        ab  = a + 8'(b);
        ev  = {1'b0,
               !(seg == 1 && dph && !wr),
               !(seg == 1 && (!dph || wr)),
               dph, 1'b1, 1'b0,
               wr && !dph && (p == HALF - 1),
               !wr && dph && (p == S + P)};
        if (!dph) begin
          tb_oe = 1'b0; exp_bus = ab;
        end else if (wr) begin
          tb_oe = 1'b0; exp_bus = wdat[b];
        end else begin
          tb_oe = 1'b1;
          tb_dout = (seg == 1) ? mem[ab] : 8'($urandom);
          exp_bus = tb_dout;
        end
        if (ev[1]) host.wr_data = wdat[b];
      end
      if (k == rst_at) begin
        reset = 1'b1; host.start = 1'b0;
      end
      @(negedge clk);
      chk("pins", pins(), ev);
      if (k == total) chk("done_bus", rtc_bus, tb_dout);
      else chk("bus", rtc_bus, exp_bus);
      if (k != total && ev[0]) chk("rd_data", host.rd_data, mem[ab]);
      if (k == rst_at) begin
        @(posedge clk); #1;
        reset = 1'b0; tb_oe = 1'b1; tb_dout = 8'($urandom);
        @(negedge clk);
        chk("rst_pins", pins(), 8'hE0);
        chk("rst_bus", rtc_bus, tb_dout);
        chk("rst_rd_data", host.rd_data, 8'h00);
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b1;
    host.start = 1'b0; host.wr_nrd = 1'b0; host.addr = 8'h00;
    host.burst_len = '0; host.wr_data = 8'h00;
    tb_oe = 1'b1; tb_dout = 8'h5A;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h22] = 8'h13;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pins", pins(), 8'hE0);
    chk("reset_rd_data", host.rd_data, 8'h00);
    chk("reset_bus", rtc_bus, 8'h5A);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    run_xfer(1'b1, 8'h21, 4'd0, 1'b0, 1'b0, -1, 8'h59); idle(2);
    run_xfer(1'b0, 8'h22, 4'd0, 1'b0, 1'b0, -1, 8'h00); idle(1);
    run_xfer(1'b0, 8'hFE, 4'd2, 1'b0, 1'b0, -1, 8'h00); idle(1);
    run_xfer(1'b1, 8'h40, 4'd0, 1'b0, 1'b0, 1 + HALF + S, 8'hA5); idle(3);
    run_xfer(1'b1, 8'h41, 4'd1, 1'b1, 1'b1, -1, 8'h3C);
    run_xfer(1'b0, 8'h22, 4'd0, 1'b0, 1'b0, -1, 8'h00); idle(1);
    run_xfer(1'b1, 8'h80, 4'd3, 1'b0, 1'b0, -1, 8'h77); idle(1);

    for (int t = 0; t < 20; t++) begin
      run_xfer(1'($urandom), 8'($urandom), BW'($urandom_range(0, 4)),
               1'($urandom), 1'($urandom), -1, 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
